// File: rtl/led_zone_mean.sv
// rtl/led_zone_mean.sv - per-zone RGB frame accumulator with serial mean divider
module led_zone_mean #(
    parameter int H_ACT = 1920,
    parameter int V_ACT = 1080
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_vld,
    input  logic       pix_sof,
    input  logic       pix_eol,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [3:0] mean_r [8],
    output logic [3:0] mean_g [8],
    output logic [3:0] mean_b [8],
    output logic       mean_vld,
    output logic       frm_err,
    output logic       ovf_err
);

    localparam int ZONE_W = H_ACT / 8;
    localparam int N      = ZONE_W * V_ACT;
    localparam int ACC_W  = 8 + $clog2(N + 1);
    localparam int COL_W  = $clog2(H_ACT + 1);
    localparam int LINE_W = $clog2(V_ACT + 1);
    localparam int SUB_W  = $clog2(ZONE_W + 1);
    localparam int NJOB   = 24;

    localparam logic [0:0] S_WAIT_SOF = 1'b0;
    localparam logic [0:0] S_ACC      = 1'b1;

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_DIV  = 2'd1;
    localparam logic [1:0] D_DONE = 2'd2;

    logic [0:0]        acc_st;
    logic [COL_W-1:0]  col;
    logic [SUB_W-1:0]  sub;
    logic [2:0]        zone;
    logic [LINE_W-1:0] line;
    logic [ACC_W-1:0]  sum     [NJOB];
    logic [ACC_W-1:0]  nxt_sum [NJOB];

    logic [1:0]        div_st;
    logic [4:0]        job;
    logic [3:0]        step;
    logic [ACC_W-1:0]  rem;
    logic [7:0]        quo;
    logic [ACC_W-1:0]  shadow  [NJOB];
    logic [3:0]        hold    [NJOB];

    logic              start;
    logic              active;
    logic              in_pic;
    logic              frame_end;
    logic [COL_W-1:0]  col_b;
    logic [SUB_W-1:0]  sub_b;
    logic [2:0]        zone_b;
    logic [LINE_W-1:0] line_b;

    // A sof beat sees a freshly cleared frame, so all "_b" values start from zero.
    always_comb begin
        start     = pix_vld && pix_sof;
        active    = pix_vld && (pix_sof || acc_st == S_ACC);
        col_b     = start ? '0 : col;
        sub_b     = start ? '0 : sub;
        zone_b    = start ? '0 : zone;
        line_b    = start ? '0 : line;
        in_pic    = col_b < COL_W'(H_ACT);
        frame_end = active && pix_eol && (line_b == LINE_W'(V_ACT - 1));
        for (int i = 0; i < NJOB; i++) begin
            nxt_sum[i] = start ? '0 : sum[i];
            if (active && in_pic && zone_b == 3'(i / 3)) begin
                if (i % 3 == 0)
                    nxt_sum[i] = nxt_sum[i] + ACC_W'(pix_r);
                else if (i % 3 == 1)
                    nxt_sum[i] = nxt_sum[i] + ACC_W'(pix_g);
                else
                    nxt_sum[i] = nxt_sum[i] + ACC_W'(pix_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_st  <= S_WAIT_SOF;
            col     <= '0;
            sub     <= '0;
            zone    <= '0;
            line    <= '0;
            frm_err <= 1'b0;
            ovf_err <= 1'b0;
            for (int i = 0; i < NJOB; i++) sum[i] <= '0;
        end else begin
            frm_err <= pix_vld && pix_sof && (acc_st == S_ACC);
            ovf_err <= frame_end && (div_st != D_IDLE);
            if (active) begin
                for (int i = 0; i < NJOB; i++) sum[i] <= nxt_sum[i];
                acc_st <= frame_end ? S_WAIT_SOF : S_ACC;
                col    <= col_b;
                sub    <= sub_b;
                zone   <= zone_b;
                line   <= line_b;
                if (pix_eol) begin
                    col  <= '0;
                    sub  <= '0;
                    zone <= '0;
                    line <= line_b + LINE_W'(1);
                end else if (in_pic) begin
                    // Zone advances via a wrapping sub-counter instead of col/ZONE_W.
                    col <= col_b + COL_W'(1);
                    if (sub_b == SUB_W'(ZONE_W - 1)) begin
                        sub  <= '0;
                        zone <= zone_b + 3'd1;
                    end else begin
                        sub <= sub_b + SUB_W'(1);
                    end
                end
            end
        end
    end

    logic [3:0]       k;
    logic [ACC_W-1:0] dsr;
    logic [ACC_W-1:0] rem_n;
    logic [7:0]       quo_n;

    // One restoring-division bit per cycle: step 1..8 resolves quotient bit 7..0.
    always_comb begin
        k     = 4'd8 - step;
        dsr   = ACC_W'(N) << k;
        rem_n = rem;
        quo_n = quo;
        if (rem >= dsr) begin
            rem_n = rem - dsr;
            quo_n = quo | (8'd1 << k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_st   <= D_IDLE;
            job      <= '0;
            step     <= '0;
            rem      <= '0;
            quo      <= '0;
            mean_vld <= 1'b0;
            for (int i = 0; i < NJOB; i++) begin
                shadow[i] <= '0;
                hold[i]   <= '0;
            end
            for (int z = 0; z < 8; z++) begin
                mean_r[z] <= '0;
                mean_g[z] <= '0;
                mean_b[z] <= '0;
            end
        end else begin
            mean_vld <= 1'b0;
            case (div_st)
                D_IDLE: begin
                    if (frame_end) begin
                        for (int i = 0; i < NJOB; i++) shadow[i] <= nxt_sum[i];
                        div_st <= D_DIV;
                        job    <= '0;
                        step   <= '0;
                    end
                end
                D_DIV: begin
                    if (step == 4'd0) begin
                        rem  <= shadow[job];
                        quo  <= '0;
                        step <= 4'd1;
                    end else begin
                        rem <= rem_n;
                        quo <= quo_n;
                        if (step == 4'd8) begin
                            hold[job] <= quo_n[7:4];
                            step      <= 4'd0;
                            if (job == 5'(NJOB - 1))
                                div_st <= D_DONE;
                            else
                                job <= job + 5'd1;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end
                end
                D_DONE: begin
                    for (int z = 0; z < 8; z++) begin
                        mean_r[z] <= hold[3*z];
                        mean_g[z] <= hold[3*z+1];
                        mean_b[z] <= hold[3*z+2];
                    end
                    mean_vld <= 1'b1;
                    div_st   <= D_IDLE;
                end
                default: div_st <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_zone_mean.sv
// tb/tb_led_zone_mean.sv - directed bench for led_zone_mean at 16x2 frame size
module tb_led_zone_mean;

    localparam int H    = 16;
    localparam int V    = 2;
    localparam int NPIX = H * V;
    localparam int LAT  = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_vld = 1'b0;
    logic       pix_sof = 1'b0;
    logic       pix_eol = 1'b0;
    logic [7:0] pix_r = 8'd0;
    logic [7:0] pix_g = 8'd0;
    logic [7:0] pix_b = 8'd0;
    logic [3:0] mean_r [8];
    logic [3:0] mean_g [8];
    logic [3:0] mean_b [8];
    logic       mean_vld;
    logic       frm_err;
    logic       ovf_err;

    led_zone_mean #(.H_ACT(H), .V_ACT(V)) dut (
        .clk      (clk),
        .rst      (rst),
        .pix_vld  (pix_vld),
        .pix_sof  (pix_sof),
        .pix_eol  (pix_eol),
        .pix_r    (pix_r),
        .pix_g    (pix_g),
        .pix_b    (pix_b),
        .mean_r   (mean_r),
        .mean_g   (mean_g),
        .mean_b   (mean_b),
        .mean_vld (mean_vld),
        .frm_err  (frm_err),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vld = 0;
    int n_frm = 0;
    int n_ovf = 0;
    int vld_cyc = 0;
    always @(negedge clk) begin
        if (mean_vld) begin
            n_vld++;
            vld_cyc = cyc;
        end
        if (frm_err) n_frm++;
        if (ovf_err) n_ovf++;
    end

    typedef struct {
        logic [7:0][7:0] zr;
        logic [7:0][7:0] zg;
        logic [7:0][7:0] zb;
        logic [7:0][3:0] er;
        logic [7:0][3:0] eg;
        logic [7:0][3:0] eb;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] fr [NPIX];
    logic [7:0] fg [NPIX];
    logic [7:0] fb [NPIX];
    int         last_t;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_vec(input vec_t v);
        for (int i = 0; i < NPIX; i++) begin
            fr[i] = v.zr[(i % H) / 2];
            fg[i] = v.zg[(i % H) / 2];
            fb[i] = v.zb[(i % H) / 2];
        end
    endtask

    task automatic fill_zero();
        for (int i = 0; i < NPIX; i++) begin
            fr[i] = 8'd0;
            fg[i] = 8'd0;
            fb[i] = 8'd0;
        end
    endtask

    task automatic send_beats(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            @(negedge clk);
            pix_vld = 1'b1;
            pix_sof = (i == 0);
            pix_eol = (i % H == H - 1);
            pix_r   = fr[i];
            pix_g   = fg[i];
            pix_b   = fb[i];
            last_t  = cyc + 1;
        end
        @(negedge clk);
        pix_vld = 1'b0;
        pix_sof = 1'b0;
        pix_eol = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_vld = 1'b0;
        end
    endtask

    task automatic wait_vld(input string name, input int t0);
        int  base;
        bit  got;
        base = n_vld;
        got  = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            #1;
            if (n_vld != base) got = 1'b1;
        end
        chk({name, " mean_vld seen"}, int'(got), 1);
        if (got) chk({name, " latency"}, vld_cyc - t0, LAT);
    endtask

    task automatic check_means(input string name, input vec_t v);
        for (int z = 0; z < 8; z++) begin
            chk($sformatf("%s mean_r[%0d]", name, z), int'(mean_r[z]), int'(v.er[z]));
            chk($sformatf("%s mean_g[%0d]", name, z), int'(mean_g[z]), int'(v.eg[z]));
            chk($sformatf("%s mean_b[%0d]", name, z), int'(mean_b[z]), int'(v.eb[z]));
        end
    endtask

    vec_t zero_v;
    vec_t t4_v;
    int   base_v, base_f, base_o, ta;

    initial begin
        vecs[0].zr = {8{8'hFF}};  vecs[0].zg = {8{8'hFF}};  vecs[0].zb = {8{8'hFF}};
        vecs[0].er = {8{4'hF}};   vecs[0].eg = {8{4'hF}};   vecs[0].eb = {8{4'hF}};

        vecs[1].zr = {8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h60, 8'h40, 8'h20, 8'h00};
        vecs[1].zg = {8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};
        vecs[1].zb = {8{8'h80}};
        vecs[1].er = {4'hE, 4'hC, 4'hA, 4'h8, 4'h6, 4'h4, 4'h2, 4'h0};
        vecs[1].eg = {4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};
        vecs[1].eb = {8{4'h8}};

        vecs[2].zr = '0; vecs[2].zg = '0; vecs[2].zb = '0;
        vecs[2].er = '0; vecs[2].eg = '0; vecs[2].eb = '0;

        vecs[3].zr = {8'h10, 8'h2F, 8'h4E, 8'h6D, 8'h8C, 8'hAB, 8'hCA, 8'hE9};
        vecs[3].zg = {8'hF0, 8'h0F, 8'hEF, 8'h1E, 8'hDE, 8'h2D, 8'hCD, 8'h3C};
        vecs[3].zb = {8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80};
        vecs[3].er = {4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE};
        vecs[3].eg = {4'hF, 4'h0, 4'hE, 4'h1, 4'hD, 4'h2, 4'hC, 4'h3};
        vecs[3].eb = {4'h7, 4'h8, 4'h7, 4'h8, 4'h7, 4'h8, 4'h7, 4'h8};

        zero_v = vecs[2];

        t4_v.zr = {8{8'h40}}; t4_v.zg = {8{8'h5A}}; t4_v.zb = {8{8'h6C}};
        t4_v.er = {8{4'h4}};  t4_v.eg = {8{4'h5}};  t4_v.eb = {8{4'h6}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_means("reset", zero_v);
        chk("reset mean_vld", int'(mean_vld), 0);
        chk("reset frm_err", int'(frm_err), 0);
        chk("reset ovf_err", int'(ovf_err), 0);

        // Beats before the first sof must be ignored.
        fill_vec(vecs[0]);
        send_beats(1, 31);
        idle(20);
        chk("pre-sof no mean_vld", n_vld, 0);

        for (int v = 0; v < 4; v++) begin
            base_v = n_vld;
            fill_vec(vecs[v]);
            send_beats(0, NPIX - 1);
            wait_vld($sformatf("vec%0d", v), last_t);
            check_means($sformatf("vec%0d", v), vecs[v]);
            idle(3);
            chk($sformatf("vec%0d single mean_vld", v), n_vld - base_v, 1);
        end

        // Truncation in zone 3 red.
        fill_zero();
        fr[6] = 8'h10; fr[7] = 8'h30; fr[22] = 8'h50; fr[23] = 8'h70;
        send_beats(0, NPIX - 1);
        wait_vld("trunc_a", last_t);
        chk("trunc_a mean_r[3]", int'(mean_r[3]), 4);
        chk("trunc_a mean_r[2]", int'(mean_r[2]), 0);
        fill_zero();
        fr[6] = 8'h1F; fr[7] = 8'h1F; fr[22] = 8'h1F; fr[23] = 8'h1F;
        send_beats(0, NPIX - 1);
        wait_vld("trunc_b", last_t);
        chk("trunc_b mean_r[3]", int'(mean_r[3]), 1);

        // sof arrives at line 1 col 5: partial frame discarded, restart on that beat.
        base_v = n_vld;
        base_f = n_frm;
        fill_vec(t4_v);
        send_beats(0, 20);
        send_beats(0, NPIX - 1);
        chk("restart frm_err pulses", n_frm - base_f, 1);
        chk("restart no early mean_vld", n_vld - base_v, 0);
        wait_vld("restart", last_t);
        check_means("restart", t4_v);

        // Second frame completes 100 cycles after the first while dividing.
        base_v = n_vld;
        base_o = n_ovf;
        fill_vec(vecs[1]);
        send_beats(0, NPIX - 1);
        ta = last_t;
        fill_vec(vecs[0]);
        idle(67);
        send_beats(0, NPIX - 1);
        wait_vld("ovf", ta);
        idle(300);
        chk("ovf ovf_err pulses", n_ovf - base_o, 1);
        chk("ovf single mean_vld", n_vld - base_v, 1);
        check_means("ovf", vecs[1]);

        // Reset at T+50 aborts the division.
        fill_vec(vecs[3]);
        send_beats(0, NPIX - 1);
        idle(48);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base_v = n_vld;
        #1;
        check_means("midrst", zero_v);
        idle(250);
        chk("midrst no mean_vld", n_vld - base_v, 0);
        send_beats(0, NPIX - 1);
        wait_vld("postrst", last_t);
        check_means("postrst", vecs[3]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
